// File: rtl/detection_window_stride.sv
// Sliding block-window assembler: buffers normalised blocks in raster order and
// emits a WIN_BX x WIN_BY block window at every stride-aligned interior position.
module detection_window_stride #(
  parameter int BLOCK_BITS = 36,
  parameter int IMG_BX     = 40,
  parameter int IMG_BY     = 30,
  parameter int WIN_BX     = 4,
  parameter int WIN_BY     = 8,
  parameter int STRIDE_X   = 1,
  parameter int STRIDE_Y   = 1,
  parameter int OUT_BITS   = BLOCK_BITS * WIN_BX * WIN_BY
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_sof,
  input  logic [BLOCK_BITS-1:0]       in_block,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_BITS-1:0]         out_window,
  output logic [$clog2(IMG_BX)-1:0]   out_x,
  output logic [$clog2(IMG_BY)-1:0]   out_y,
  output logic                        out_eof
);

  localparam int XW  = $clog2(IMG_BX);
  localparam int YW  = $clog2(IMG_BY);
  localparam int PXW = (STRIDE_X > 1) ? $clog2(STRIDE_X) : 1;
  localparam int PYW = (STRIDE_Y > 1) ? $clog2(STRIDE_Y) : 1;
  localparam int NLB = WIN_BY - 1;

  // Column/row of the bottom-right block of the last window in a frame.
  localparam int LAST_QX = ((IMG_BX - WIN_BX) / STRIDE_X) * STRIDE_X + WIN_BX - 1;
  localparam int LAST_QY = ((IMG_BY - WIN_BY) / STRIDE_Y) * STRIDE_Y + WIN_BY - 1;

  localparam logic [XW-1:0]  COL_LAST = XW'(IMG_BX - 1);
  localparam logic [YW-1:0]  ROW_LAST = YW'(IMG_BY - 1);
  localparam logic [XW-1:0]  COL_Q    = XW'(WIN_BX - 1);
  localparam logic [YW-1:0]  ROW_Q    = YW'(WIN_BY - 1);
  localparam logic [XW-1:0]  COL_EOF  = XW'(LAST_QX);
  localparam logic [YW-1:0]  ROW_EOF  = YW'(LAST_QY);
  localparam logic [PXW-1:0] PX_LAST  = PXW'(STRIDE_X - 1);
  localparam logic [PYW-1:0] PY_LAST  = PYW'(STRIDE_Y - 1);

  logic [XW-1:0]  col, col_eff, col_nxt;
  logic [YW-1:0]  row, row_eff, row_nxt;
  logic [PXW-1:0] px, px_eff, px_nxt;
  logic [PYW-1:0] py, py_eff, py_nxt;
  logic           accept, qualify, col_wrap, row_wrap;

  logic [BLOCK_BITS-1:0] lb [NLB][IMG_BX];
  logic [BLOCK_BITS-1:0] new_col [WIN_BY];
  logic [OUT_BITS-1:0]   win, win_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A start-of-frame block is treated as position (0,0) with fresh phases.
  assign col_eff  = in_sof ? '0 : col;
  assign row_eff  = in_sof ? '0 : row;
  assign px_eff   = in_sof ? '0 : px;
  assign py_eff   = in_sof ? '0 : py;

  assign col_wrap = (col_eff == COL_LAST);
  assign row_wrap = (row_eff == ROW_LAST);

  // Phases stay at zero until the window first fits, so zero phase marks alignment.
  assign qualify  = (col_eff >= COL_Q) && (row_eff >= ROW_Q) &&
                    (px_eff == '0) && (py_eff == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    col_nxt = col_eff;
    row_nxt = row_eff;
    px_nxt  = px_eff;
    py_nxt  = py_eff;
    if (col_wrap) begin
      col_nxt = '0;
      px_nxt  = '0;
      row_nxt = row_wrap ? '0 : row_eff + 1'b1;
      if (row_wrap || (row_eff < ROW_Q) || (py_eff == PY_LAST))
        py_nxt = '0;
      else
        py_nxt = py_eff + 1'b1;
    end else begin
      col_nxt = col_eff + 1'b1;
      if ((col_eff < COL_Q) || (px_eff == PX_LAST))
        px_nxt = '0;
      else
        px_nxt = px_eff + 1'b1;
    end
  end

  // Incoming column: oldest line buffer on top, the live block at the bottom.
  always_comb begin
    for (int r = 0; r < WIN_BY; r++) new_col[r] = '0;
    new_col[WIN_BY-1] = in_block;
    for (int k = 0; k < NLB; k++) new_col[NLB-1-k] = lb[k][col_eff];
  end

  always_comb begin
    win_nxt = win;
    for (int r = 0; r < WIN_BY; r++) begin
      for (int c = 0; c < WIN_BX - 1; c++)
        win_nxt[(r*WIN_BX+c)*BLOCK_BITS +: BLOCK_BITS] =
          win[(r*WIN_BX+c+1)*BLOCK_BITS +: BLOCK_BITS];
      win_nxt[(r*WIN_BX+WIN_BX-1)*BLOCK_BITS +: BLOCK_BITS] = new_col[r];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
      px  <= '0;
      py  <= '0;
    end else if (accept) begin
      col <= col_nxt;
      row <= row_nxt;
      px  <= px_nxt;
      py  <= py_nxt;
    end
  end

  // NOTE: line buffers and the window shift register are pure datapath with no reset;
  // qualification guarantees they are refilled before any of their contents is emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      win <= win_nxt;
      for (int k = 0; k < NLB; k++) lb[k][col_eff] <= new_col[NLB-k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_window <= '0;
      out_x      <= '0;
      out_y      <= '0;
      out_eof    <= 1'b0;
    end else if (accept && qualify) begin
      out_valid  <= 1'b1;
      out_window <= win_nxt;
      out_x      <= col_eff - COL_Q;
      out_y      <= row_eff - ROW_Q;
      out_eof    <= (col_eff == COL_EOF) && (row_eff == ROW_EOF);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_detection_window_stride.sv
// Bench for detection_window_stride: an 8x4 image with 2x2 windows, stride 1 (u0)
// and stride 2 (u1), checked against a frame-level reference model.
module tb_detection_window_stride;

  localparam int BB  = 8;
  localparam int IBX = 8;
  localparam int IBY = 4;
  localparam int WBX = 2;
  localparam int WBY = 2;

  typedef struct packed {
    logic [31:0] w;
    logic [2:0]  x;
    logic [1:0]  y;
    logic        eof;
  } win_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        in_sof    [2];
  logic [7:0]  in_block  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_window[2];
  logic [2:0]  out_x     [2];
  logic [1:0]  out_y     [2];
  logic        out_eof   [2];

  int   checks   = 0;
  int   failures = 0;
  int   got_cnt [2];
  win_t exp_q0[$];
  win_t exp_q1[$];
  logic [31:0] win22;

  always #5 clk = ~clk;

  detection_window_stride #(
    .BLOCK_BITS(BB), .IMG_BX(IBX), .IMG_BY(IBY), .WIN_BX(WBX), .WIN_BY(WBY),
    .STRIDE_X(1), .STRIDE_Y(1)
  ) u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_sof(in_sof[0]), .in_block(in_block[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_window(out_window[0]),
    .out_x(out_x[0]), .out_y(out_y[0]), .out_eof(out_eof[0])
  );

  detection_window_stride #(
    .BLOCK_BITS(BB), .IMG_BX(IBX), .IMG_BY(IBY), .WIN_BX(WBX), .WIN_BY(WBY),
    .STRIDE_X(2), .STRIDE_Y(2)
  ) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_sof(in_sof[1]), .in_block(in_block[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_window(out_window[1]),
    .out_x(out_x[1]), .out_y(out_y[1]), .out_eof(out_eof[1])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: every stride-aligned window whose bottom-right block lies among
  // the first n blocks of a frame whose block at (r,c) is base + r*IBX + c.
  task automatic expect_frame(input int sel, input int base, input int n);
    int   s;
    int   last_x;
    int   last_y;
    win_t e;
    s = (sel == 0) ? 1 : 2;
    last_x = 0;
    last_y = 0;
    for (int x = 0; x <= IBX - WBX; x += s) last_x = x;
    for (int y = 0; y <= IBY - WBY; y += s) last_y = y;
    for (int y = 0; y <= IBY - WBY; y += s) begin
      for (int x = 0; x <= IBX - WBX; x += s) begin
        if ((y + WBY - 1) * IBX + (x + WBX - 1) < n) begin
          for (int r = 0; r < WBY; r++)
            for (int c = 0; c < WBX; c++)
              e.w[(r*WBX+c)*BB +: BB] = 8'(base + (y + r) * IBX + x + c);
          e.x   = 3'(x);
          e.y   = 2'(y);
          e.eof = (x == last_x) && (y == last_y);
          if (sel == 0) exp_q0.push_back(e);
          else          exp_q1.push_back(e);
        end
      end
    end
  endtask

  // Output monitor: a window is consumed at the edge following a negedge
  // where out_valid and out_ready are both high.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      for (int s = 0; s < 2; s++) begin
        if (out_valid[s] && out_ready[s]) begin
          win_t got;
          win_t e;
          got = {out_window[s], out_x[s], out_y[s], out_eof[s]};
          got_cnt[s]++;
          if (s == 1 && out_x[1] == 3'd2 && out_y[1] == 2'd2) win22 = out_window[1];
          if ((s == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            check($sformatf("unexpected_window_u%0d", s), out_valid[s], 1'b0);
          end else begin
            e = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("window_u%0d_x%0d_y%0d", s, e.x, e.y), got, e);
          end
        end
      end
    end
  end

  // Starts and ends 1 time unit after a rising edge.
  task automatic send(input int sel, input int base, input int first, input int last,
                      input bit sof, input int pv, input int pr);
    int idx;
    int budget;
    idx = first;
    budget = 3000;
    while (idx < last && budget > 0) begin
      out_ready[sel] = ($urandom_range(0, 99) < pr);
      if ($urandom_range(0, 99) < pv) begin
        in_valid[sel] = 1'b1;
        in_block[sel] = 8'(base + idx);
        in_sof[sel]   = sof && (idx == 0);
      end else begin
        in_valid[sel] = 1'b0;
        in_block[sel] = 8'($urandom);
        in_sof[sel]   = 1'($urandom);
      end
      @(negedge clk);
      if (in_valid[sel] && in_ready[sel]) idx++;
      @(posedge clk);
      #1;
      budget--;
    end
    in_valid[sel] = 1'b0;
    in_sof[sel]   = 1'b0;
    check($sformatf("send_done_u%0d", sel), idx, last);
  endtask

  task automatic drain(input int sel);
    int budget;
    budget = 200;
    out_ready[sel] = 1'b1;
    while ((sel == 0 ? exp_q0.size() : exp_q1.size()) > 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check($sformatf("drain_left_u%0d", sel), (sel == 0 ? exp_q0.size() : exp_q1.size()), 0);
    @(negedge clk);
    check($sformatf("drain_idle_u%0d", sel), out_valid[sel], 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_valid[s] = 1'b0; in_sof[s] = 1'b0; in_block[s] = '0; out_ready[s] = 1'b0;
      got_cnt[s] = 0;
    end
    win22 = '0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_out_valid", out_valid[0], 1'b0);
    check("rst_in_ready",  in_ready[0],  1'b1);
    check("rst_window",    out_window[0], 32'h0);
    check("rst_xy_eof",    {out_x[0], out_y[0], out_eof[0]}, 6'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Stride 1, blocks = raster index: 21 windows, last (6,2) with eof.
    got_cnt[0] = 0;
    expect_frame(0, 0, 32);
    send(0, 0, 0, 32, 1'b1, 100, 100);
    drain(0);
    check("count_stride1", got_cnt[0], 21);

    // Stride 2: 8 windows, (2,2) = {18,19,26,27}.
    got_cnt[1] = 0;
    expect_frame(1, 0, 32);
    send(1, 0, 0, 32, 1'b1, 100, 100);
    drain(1);
    check("count_stride2", got_cnt[1], 8);
    check("pack_2_2", win22, 32'h1B1A1312);

    // Hold the first window for 5 cycles while a garbage block is offered.
    got_cnt[0] = 0;
    expect_frame(0, 0, 32);
    send(0, 0, 0, 10, 1'b1, 100, 0);
    in_valid[0] = 1'b1;
    in_block[0] = 8'hEE;
    out_ready[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready",  in_ready[0],   1'b0);
      check("stall_out_valid", out_valid[0],  1'b1);
      check("stall_window",    out_window[0], 32'h09080100);
      check("stall_xy",        {out_x[0], out_y[0]}, 5'h0);
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    send(0, 0, 10, 32, 1'b0, 80, 60);
    drain(0);
    check("count_stall", got_cnt[0], 21);

    // Random valid/ready over three frames on each instance.
    for (int s = 0; s < 2; s++) begin
      got_cnt[s] = 0;
      for (int f = 0; f < 3; f++) begin
        int base;
        base = int'($urandom_range(0, 255));
        expect_frame(s, base, 32);
        send(s, base, 0, 32, 1'b1, 70, 60);
      end
      drain(s);
      check($sformatf("count_random_u%0d", s), got_cnt[s], (s == 0) ? 63 : 24);
    end

    // Resync: in_sof on block 13 starts a new frame; the 13-block partial
    // frame yields only its completed windows.
    got_cnt[0] = 0;
    expect_frame(0, 8'h40, 13);
    send(0, 8'h40, 0, 13, 1'b1, 100, 100);
    expect_frame(0, 8'h80, 32);
    send(0, 8'h80, 0, 32, 1'b1, 80, 70);
    drain(0);
    check("count_sof", got_cnt[0], 4 + 21);

    // Async reset while a window is pending.
    send(0, 8'h10, 0, 10, 1'b1, 100, 0);
    @(negedge clk);
    check("pre_rst_valid", out_valid[0], 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid",  out_valid[0],  1'b0);
    check("async_rst_ready",  in_ready[0],   1'b1);
    check("async_rst_window", out_window[0], 32'h0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    got_cnt[0] = 0;
    expect_frame(0, 8'h20, 32);
    send(0, 8'h20, 0, 32, 1'b0, 100, 100);
    drain(0);
    check("count_after_rst", got_cnt[0], 21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
